if1_wide: RTL and testbench
===========================

// Module: if1_wide
// PURPOSE
//  Parametrised fetch-address stage; next generation of the 2-wide IF1. Generates one
//  aligned fetch block of FETCH_W instructions per cycle and applies BTB redirects at slot
//  granularity. Entries go through a FETCH_Q-deep decoupling queue with a valid/ready
//  handshake to IF2, which replaces the old busy stall. Misaligned redirect targets raise
//  a precise fetch exception.
// PARAMETERS
//  START_ADDR  32'h0000_0000  reset PC
//  FETCH_W     4              instructions per fetch block (power of 2, 2..8); block = FETCH_W*4 bytes
//  FETCH_Q     4              decoupling queue depth (power of 2, >=2)
// PORTS
//  cpu_clk_i         in   1         core clock
//  reset_ni          in   1         asynchronous, active-low reset
//  flush_i           in   1         redirect from backend; highest priority
//  flush_pc_i        in   32        redirect target
//  if1_current_pc_o  out  32        PC presented to BTB/ICache this cycle
//  valid_cyc_o       out  1         this cycle's lookup is consumed (entry pushed)
//  btb_vld_i         in   1         BTB hit for current block
//  btb_slot_i        in   SW        slot of hit branch in block, SW=$clog2(FETCH_W)
//  btb_btype_i       in   2         00 cond, others unconditional
//  btb_bm_pred_i     in   2         bimodal counter; [1]=taken
//  btb_target_i      in   32        predicted target
//  btb_index_i/btb_way_i in 1 each  BTB bookkeeping, passed through
//  if2_vld_o         out  1         queue head valid
//  if2_rdy_i         in   1         IF2 accepts head this cycle
//  if2_pc_o          out  32        PC of first valid lane
//  if2_lane_mask_o   out  FETCH_W   valid instruction lanes
//  if2_btb_hit_o, if2_btb_slot_o, if2_btype_o, if2_bm_pred_o, if2_btb_target_o,
//  if2_btb_index_o, if2_btb_way_o   out  as inputs; prediction of this entry
//  if2_excp_vld_o    out  1         entry carries a fetch exception
//  if2_excp_code_o   out  4         exception cause
// BEHAVIOUR
//  - Reset (async assert, sync release): pc=START_ADDR, queue empty, halt=0; all outputs 0.
//  - off = pc[2+SW-1:2]; base = pc with low 2+SW bits cleared.
//  - hit_ok = btb_vld_i & btb_slot_i>=off; a hit below off is ignored (hit_ok=0).
//  - taken = hit_ok & (btype==2'b00 ? bm_pred[1] : 1).
//  - next_pc = taken ? btb_target_i : base + FETCH_W*4 (32-bit wrap allowed).
//  - lane_mask bit i = (i>=off) & (i <= (taken ? slot : FETCH_W-1)); never all-zero on a normal entry.
//  - valid_cyc_o = !flush_i & !halt & (count<FETCH_Q | (if2_vld_o & if2_rdy_i)).
//  - valid_cyc_o=1: push {pc, mask, hit_ok, btb fields, excp=0}; pc<=next_pc. Else pc holds.
//  - Pop when if2_vld_o & if2_rdy_i. Push and pop in the same cycle are legal at full and at
//    count==1. Combinational path from if2_rdy_i to valid_cyc_o is permitted.
//  - Head payload outputs are zero when the queue is empty.
//  - flush_i: queue cleared and pc<=flush_pc_i at the same edge; if2_vld_o=0 the next cycle;
//    halt cleared. No push or pop takes effect that cycle.
//  - flush_pc_i[1:0]!=0: the first cycle after the flush pushes one exception entry
//    (pc=flush_pc, mask=0, hit=0, excp_vld=1, code=IF_EXCP_MISALIGN=4'd0). Then halt=1 and
//    valid_cyc_o=0 until the next flush. If that cycle is a queue-full case, the push waits.
//  - Reset mid-operation discards the queue and any pending exception.
// STRUCTURE
//  - if_pkg: fetch_entry_t struct, IF_EXCP_* codes, btype_e (BT_COND=2'b00,...).
//  - Sub-module fetch_queue #(type T, DEPTH): circular FIFO with ptr+wrap bit, clear,
//    and full/empty flags. if1_wide holds the PC, halt and exception-pending logic.
// TESTING  (FETCH_W=4, FETCH_Q=4)
//  - Reset, rdy=1, no hits -> pcs 0x0,0x10,0x20..., mask 4'b1111, one entry per cycle.
//  - flush to 0x108, no hit -> entry pc 0x108, mask 4'b1100; next pc 0x110.
//  - pc 0x100, hit slot 1, uncond, target 0x400 -> mask 4'b0011; next pc 0x400.
//  - pc 0x108, hit slot 0 -> hit ignored, hit_o=0, next 0x110.
//  - Cond hit bm_pred=01 -> next 0x110, mask 1111.
//  - rdy=0 for 6 cycles -> exactly 4 pushes, valid_cyc_o=0 after; rdy=1 -> FIFO order kept.
//  - Full queue with rdy=1 -> push and pop in the same cycle; count stays 4.
//  - flush to 0x202 -> one entry excp_vld=1, code 0, mask 0; no further pushes.
//    flush to 0x300 -> normal fetch resumes.
//  - Flush with the queue full and rdy=1 -> queue empty next cycle; stale entries never seen.
//  - reset_ni low mid-stream, asynchronously -> if2_vld_o=0 immediately; pc=START_ADDR on release.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types for the fetch front end: queue entry layout, branch types and
// exception causes. Widths are sized for the widest supported fetch block.
package if_pkg;

    localparam int unsigned MAX_FETCH_W = 8;
    localparam int unsigned MAX_SW      = 3;

    localparam logic [3:0] IF_EXCP_MISALIGN = 4'd0;

    typedef enum logic [1:0] {
        BT_COND = 2'b00,
        BT_JUMP = 2'b01,
        BT_CALL = 2'b10,
        BT_RET  = 2'b11
    } btype_e;

    typedef struct packed {
        logic [31:0]            pc;
        logic [MAX_FETCH_W-1:0] mask;
        logic                   btb_hit;
        logic [MAX_SW-1:0]      btb_slot;
        logic [1:0]             btype;
        logic [1:0]             bm_pred;
        logic [31:0]            btb_target;
        logic                   btb_index;
        logic                   btb_way;
        logic                   excp_vld;
        logic [3:0]             excp_code;
    } fetch_entry_t;

    // Lanes from first_lane up to and including last_lane are valid.
    function automatic logic [MAX_FETCH_W-1:0] lane_mask_f(input logic [MAX_SW-1:0] first_lane,
                                                           input logic [MAX_SW-1:0] last_lane);
        logic [MAX_FETCH_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_FETCH_W; i++) begin
            m[i] = (MAX_SW'(i) >= first_lane) && (MAX_SW'(i) <= last_lane);
        end
        return m;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO using read/write pointers with an extra wrap bit so full and
// empty are distinguished without a separate counter. Head reads as zero when empty.
module fetch_queue #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic push_i,
    input  logic pop_i,
    input  T     wdata_i,
    output T     rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    T            mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A push while full is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_ONE;
            if (do_pop)  rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/if1_wide.sv
// Fetch-address stage: one aligned FETCH_W-instruction block per cycle, BTB redirect
// at slot granularity, decoupling queue towards IF2, misaligned-target exception.
module if1_wide
    import if_pkg::*;
#(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int unsigned FETCH_W    = 4,
    parameter int unsigned FETCH_Q    = 4
) (
    input  logic                       cpu_clk_i,
    input  logic                       reset_ni,
    input  logic                       flush_i,
    input  logic [31:0]                flush_pc_i,
    output logic [31:0]                if1_current_pc_o,
    output logic                       valid_cyc_o,
    input  logic                       btb_vld_i,
    input  logic [$clog2(FETCH_W)-1:0] btb_slot_i,
    input  logic [1:0]                 btb_btype_i,
    input  logic [1:0]                 btb_bm_pred_i,
    input  logic [31:0]                btb_target_i,
    input  logic                       btb_index_i,
    input  logic                       btb_way_i,
    output logic                       if2_vld_o,
    input  logic                       if2_rdy_i,
    output logic [31:0]                if2_pc_o,
    output logic [FETCH_W-1:0]         if2_lane_mask_o,
    output logic                       if2_btb_hit_o,
    output logic [$clog2(FETCH_W)-1:0] if2_btb_slot_o,
    output logic [1:0]                 if2_btype_o,
    output logic [1:0]                 if2_bm_pred_o,
    output logic [31:0]                if2_btb_target_o,
    output logic                       if2_btb_index_o,
    output logic                       if2_btb_way_o,
    output logic                       if2_excp_vld_o,
    output logic [3:0]                 if2_excp_code_o
);

    localparam int unsigned SW        = $clog2(FETCH_W);
    localparam logic [31:0] BLK_BYTES = 32'(FETCH_W * 4);
    localparam logic [31:0] BLK_MASK  = 32'(FETCH_W * 4 - 1);

    logic [31:0]            pc_q, pc_d;
    logic                   halt_q, halt_d;
    logic                   excp_pend_q, excp_pend_d;

    logic [SW-1:0]          off;
    logic [31:0]            base;
    logic [31:0]            next_pc;
    logic                   hit_ok;
    logic                   taken;
    logic [MAX_FETCH_W-1:0] mask_full;
    logic [FETCH_W-1:0]     lane_mask;

    logic                   q_full;
    logic                   q_empty;
    logic                   pop;
    logic                   can_push;
    fetch_entry_t           wentry;
    fetch_entry_t           head;

    assign off     = pc_q[2 +: SW];
    assign base    = pc_q & ~BLK_MASK;
    assign hit_ok  = btb_vld_i && (btb_slot_i >= off);
    assign taken   = hit_ok && ((btb_btype_i == BT_COND) ? btb_bm_pred_i[1] : 1'b1);
    assign next_pc = taken ? btb_target_i : base + BLK_BYTES;

    assign mask_full = lane_mask_f(MAX_SW'(off),
                                   taken ? MAX_SW'(btb_slot_i) : MAX_SW'(FETCH_W - 1));
    assign lane_mask = mask_full[FETCH_W-1:0];

    // rdy feeds valid_cyc combinationally so a full queue can still accept a block.
    assign if2_vld_o   = !q_empty;
    assign pop         = if2_vld_o && if2_rdy_i && !flush_i;
    assign can_push    = !q_full || (if2_vld_o && if2_rdy_i);
    assign valid_cyc_o = !flush_i && !halt_q && can_push;

    always_comb begin
        wentry    = '0;
        wentry.pc = pc_q;
        if (excp_pend_q) begin
            wentry.excp_vld  = 1'b1;
            wentry.excp_code = IF_EXCP_MISALIGN;
        end else begin
            wentry.mask       = MAX_FETCH_W'(lane_mask);
            wentry.btb_hit    = hit_ok;
            wentry.btb_slot   = MAX_SW'(btb_slot_i);
            wentry.btype      = btb_btype_i;
            wentry.bm_pred    = btb_bm_pred_i;
            wentry.btb_target = btb_target_i;
            wentry.btb_index  = btb_index_i;
            wentry.btb_way    = btb_way_i;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        halt_d      = halt_q;
        excp_pend_d = excp_pend_q;
        if (flush_i) begin
            pc_d        = flush_pc_i;
            halt_d      = 1'b0;
            excp_pend_d = |flush_pc_i[1:0];
        end else if (valid_cyc_o) begin
            if (excp_pend_q) begin
                // Exception entry is the last thing fetched until the next redirect.
                excp_pend_d = 1'b0;
                halt_d      = 1'b1;
            end else begin
                pc_d = next_pc;
            end
        end
    end

    always_ff @(posedge cpu_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pc_q        <= START_ADDR;
            halt_q      <= 1'b0;
            excp_pend_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            halt_q      <= halt_d;
            excp_pend_q <= excp_pend_d;
        end
    end

    fetch_queue #(
        .T     (fetch_entry_t),
        .DEPTH (FETCH_Q)
    ) u_fetch_queue (
        .clk_i   (cpu_clk_i),
        .rst_ni  (reset_ni),
        .clear_i (flush_i),
        .push_i  (valid_cyc_o),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign if1_current_pc_o = pc_q;
    assign if2_pc_o         = head.pc;
    assign if2_lane_mask_o  = head.mask[FETCH_W-1:0];
    assign if2_btb_hit_o    = head.btb_hit;
    assign if2_btb_slot_o   = head.btb_slot[SW-1:0];
    assign if2_btype_o      = head.btype;
    assign if2_bm_pred_o    = head.bm_pred;
    assign if2_btb_target_o = head.btb_target;
    assign if2_btb_index_o  = head.btb_index;
    assign if2_btb_way_o    = head.btb_way;
    assign if2_excp_vld_o   = head.excp_vld;
    assign if2_excp_code_o  = head.excp_code;

endmodule

// File: tb/tb_if1_wide.sv
// Directed bench for if1_wide with FETCH_W=4, FETCH_Q=4, START_ADDR=0.
module tb_if1_wide;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] cur_pc;
    logic        valid_cyc;
    logic        btb_vld;
    logic [1:0]  btb_slot;
    logic [1:0]  btb_btype;
    logic [1:0]  btb_bm;
    logic [31:0] btb_target;
    logic        btb_index;
    logic        btb_way;
    logic        if2_vld;
    logic        if2_rdy;
    logic [31:0] if2_pc;
    logic [3:0]  if2_mask;
    logic        if2_hit;
    logic [1:0]  if2_slot;
    logic [1:0]  if2_btype;
    logic [1:0]  if2_bm;
    logic [31:0] if2_target;
    logic        if2_index;
    logic        if2_way;
    logic        if2_excp;
    logic [3:0]  if2_code;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    if1_wide #(
        .START_ADDR (32'h0000_0000),
        .FETCH_W    (4),
        .FETCH_Q    (4)
    ) dut (
        .cpu_clk_i        (clk),
        .reset_ni         (rst_n),
        .flush_i          (flush),
        .flush_pc_i       (flush_pc),
        .if1_current_pc_o (cur_pc),
        .valid_cyc_o      (valid_cyc),
        .btb_vld_i        (btb_vld),
        .btb_slot_i       (btb_slot),
        .btb_btype_i      (btb_btype),
        .btb_bm_pred_i    (btb_bm),
        .btb_target_i     (btb_target),
        .btb_index_i      (btb_index),
        .btb_way_i        (btb_way),
        .if2_vld_o        (if2_vld),
        .if2_rdy_i        (if2_rdy),
        .if2_pc_o         (if2_pc),
        .if2_lane_mask_o  (if2_mask),
        .if2_btb_hit_o    (if2_hit),
        .if2_btb_slot_o   (if2_slot),
        .if2_btype_o      (if2_btype),
        .if2_bm_pred_o    (if2_bm),
        .if2_btb_target_o (if2_target),
        .if2_btb_index_o  (if2_index),
        .if2_btb_way_o    (if2_way),
        .if2_excp_vld_o   (if2_excp),
        .if2_excp_code_o  (if2_code)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush    = 1'b1;
        flush_pc = target;
        tick();
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; flush_pc = '0; if2_rdy = 1'b1;
        btb_vld = 1'b0; btb_slot = '0; btb_btype = '0; btb_bm = '0;
        btb_target = '0; btb_index = 1'b0; btb_way = 1'b0;
        repeat (2) tick();
        #1;
        checks++; if (if2_vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", if2_vld); else passed++;
        checks++; if (cur_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", cur_pc); else passed++;
        checks++; if (if2_mask !== 4'h0) $display("FAIL reset_mask: got %h want 0", if2_mask); else passed++;
        checks++; if (if2_excp !== 1'b0) $display("FAIL reset_excp: got %b want 0", if2_excp); else passed++;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (valid_cyc !== 1'b1) $display("FAIL rel_valid: got %b want 1", valid_cyc); else passed++;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 4; k++) begin
            tick();
            #1;
            checks++; if (cur_pc !== 32'(k * 16)) $display("FAIL seq_pc%0d: got %h want %h", k, cur_pc, 32'(k * 16)); else passed++;
            checks++; if (if2_vld !== 1'b1 || if2_pc !== 32'((k - 1) * 16) || if2_mask !== 4'hf)
                $display("FAIL seq_head%0d: got vld=%b pc=%h mask=%h want vld=1 pc=%h mask=f", k, if2_vld, if2_pc, if2_mask, 32'((k - 1) * 16));
            else passed++;
        end
    endtask

    task automatic test_flush_offset();
        do_flush(32'h108);
        #1;
        checks++; if (if2_vld !== 1'b0 || cur_pc !== 32'h108) $display("FAIL flush_state: got vld=%b pc=%h want vld=0 pc=108", if2_vld, cur_pc); else passed++;
        tick();
        #1;
        checks++; if (if2_pc !== 32'h108 || if2_mask !== 4'b1100) $display("FAIL flush_entry: got pc=%h mask=%b want pc=108 mask=1100", if2_pc, if2_mask); else passed++;
        checks++; if (cur_pc !== 32'h110) $display("FAIL flush_next: got %h want 110", cur_pc); else passed++;
    endtask

    task automatic test_hit_taken();
        do_flush(32'h100);
        btb_vld = 1'b1; btb_slot = 2'd1; btb_btype = 2'b01; btb_bm = 2'b00;
        btb_target = 32'h400; btb_index = 1'b1; btb_way = 1'b1;
        tick();
        btb_vld = 1'b0;
        #1;
        checks++; if (cur_pc !== 32'h400) $display("FAIL taken_next: got %h want 400", cur_pc); else passed++;
        checks++; if (if2_mask !== 4'b0011 || if2_hit !== 1'b1 || if2_slot !== 2'd1)
            $display("FAIL taken_entry: got mask=%b hit=%b slot=%0d want mask=0011 hit=1 slot=1", if2_mask, if2_hit, if2_slot);
        else passed++;
        checks++; if (if2_target !== 32'h400 || if2_index !== 1'b1 || if2_way !== 1'b1)
            $display("FAIL taken_fields: got tgt=%h idx=%b way=%b want tgt=400 idx=1 way=1", if2_target, if2_index, if2_way);
        else passed++;
        btb_index = 1'b0; btb_way = 1'b0;
    endtask

    task automatic test_hit_ignored();
        do_flush(32'h108);
        btb_vld = 1'b1; btb_slot = 2'd0; btb_btype = 2'b01; btb_target = 32'h400;
        tick();
        btb_vld = 1'b0;
        #1;
        checks++; if (cur_pc !== 32'h110) $display("FAIL ignored_next: got %h want 110", cur_pc); else passed++;
        checks++; if (if2_hit !== 1'b0 || if2_mask !== 4'b1100) $display("FAIL ignored_entry: got hit=%b mask=%b want hit=0 mask=1100", if2_hit, if2_mask); else passed++;
    endtask

    task automatic test_cond_not_taken();
        do_flush(32'h100);
        btb_vld = 1'b1; btb_slot = 2'd2; btb_btype = 2'b00; btb_bm = 2'b01; btb_target = 32'h400;
        tick();
        btb_vld = 1'b0;
        #1;
        checks++; if (cur_pc !== 32'h110) $display("FAIL cond_next: got %h want 110", cur_pc); else passed++;
        checks++; if (if2_mask !== 4'hf || if2_hit !== 1'b1 || if2_bm !== 2'b01)
            $display("FAIL cond_entry: got mask=%b hit=%b bm=%b want mask=1111 hit=1 bm=01", if2_mask, if2_hit, if2_bm);
        else passed++;
        btb_bm = 2'b00; btb_btype = 2'b00;
    endtask

    task automatic test_back_to_back();
        int pushes;
        pushes = 0;
        do_flush(32'h500);
        if2_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (valid_cyc === 1'b1) pushes++;
            tick();
        end
        #1;
        checks++; if (pushes !== 4) $display("FAIL bp_pushes: got %0d want 4", pushes); else passed++;
        checks++; if (valid_cyc !== 1'b0 || cur_pc !== 32'h540) $display("FAIL bp_stall: got valid=%b pc=%h want valid=0 pc=540", valid_cyc, cur_pc); else passed++;
        checks++; if (if2_pc !== 32'h500) $display("FAIL bp_head: got %h want 500", if2_pc); else passed++;
        if2_rdy = 1'b1;
        #1;
        checks++; if (valid_cyc !== 1'b1) $display("FAIL full_pushpop: got %b want 1", valid_cyc); else passed++;
        for (int j = 1; j <= 4; j++) begin
            tick();
            #1;
            checks++; if (if2_pc !== 32'(32'h500 + j * 16)) $display("FAIL order%0d: got %h want %h", j, if2_pc, 32'(32'h500 + j * 16)); else passed++;
        end
        if2_rdy = 1'b0;
        #1;
        checks++; if (valid_cyc !== 1'b0) $display("FAIL full_count: got valid=%b want 0", valid_cyc); else passed++;
    endtask

    task automatic test_misalign();
        do_flush(32'h202);
        #1;
        checks++; if (valid_cyc !== 1'b1 || if2_vld !== 1'b0) $display("FAIL excp_push: got valid=%b vld=%b want 1/0", valid_cyc, if2_vld); else passed++;
        tick();
        #1;
        checks++; if (if2_vld !== 1'b1 || if2_excp !== 1'b1 || if2_code !== 4'd0)
            $display("FAIL excp_entry: got vld=%b excp=%b code=%0d want 1/1/0", if2_vld, if2_excp, if2_code);
        else passed++;
        checks++; if (if2_pc !== 32'h202 || if2_mask !== 4'h0 || if2_hit !== 1'b0)
            $display("FAIL excp_fields: got pc=%h mask=%b hit=%b want 202/0000/0", if2_pc, if2_mask, if2_hit);
        else passed++;
        checks++; if (valid_cyc !== 1'b0) $display("FAIL excp_halt: got %b want 0", valid_cyc); else passed++;
        if2_rdy = 1'b1;
        tick();
        #1;
        checks++; if (if2_vld !== 1'b0 || valid_cyc !== 1'b0) $display("FAIL excp_drain: got vld=%b valid=%b want 0/0", if2_vld, valid_cyc); else passed++;
        do_flush(32'h300);
        #1;
        checks++; if (valid_cyc !== 1'b1) $display("FAIL resume_valid: got %b want 1", valid_cyc); else passed++;
        tick();
        #1;
        checks++; if (if2_pc !== 32'h300 || if2_excp !== 1'b0 || if2_mask !== 4'hf)
            $display("FAIL resume_entry: got pc=%h excp=%b mask=%b want 300/0/1111", if2_pc, if2_excp, if2_mask);
        else passed++;
    endtask

    task automatic test_flush_full();
        if2_rdy = 1'b0;
        repeat (5) tick();
        if2_rdy  = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'h700;
        #1;
        checks++; if (valid_cyc !== 1'b0) $display("FAIL ff_valid: got %b want 0", valid_cyc); else passed++;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (if2_vld !== 1'b0 || cur_pc !== 32'h700) $display("FAIL ff_clear: got vld=%b pc=%h want 0/700", if2_vld, cur_pc); else passed++;
        tick();
        #1;
        checks++; if (if2_pc !== 32'h700) $display("FAIL ff_first: got %h want 700", if2_pc); else passed++;
    endtask

    task automatic test_async_reset();
        if2_rdy = 1'b1;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (if2_vld !== 1'b0 || cur_pc !== 32'h0) $display("FAIL ar_assert: got vld=%b pc=%h want 0/0", if2_vld, cur_pc); else passed++;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (cur_pc !== 32'h0 || if2_vld !== 1'b0) $display("FAIL ar_release: got pc=%h vld=%b want 0/0", cur_pc, if2_vld); else passed++;
        tick();
        #1;
        checks++; if (cur_pc !== 32'h10 || if2_pc !== 32'h0 || if2_vld !== 1'b1)
            $display("FAIL ar_restart: got pc=%h head=%h vld=%b want 10/0/1", cur_pc, if2_pc, if2_vld);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_flush_offset();
        test_hit_taken();
        test_hit_ignored();
        test_cond_not_taken();
        test_back_to_back();
        test_misalign();
        test_flush_full();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
